// File: rtl/rgb_sdram_wr_ctrl.sv
// RGB565 pixel FIFO that drains fixed-length write bursts to the SDRAM controller at linear frame addresses.
// Optional two-bank ping-pong frame store when PINGPONG_EN is defined.
module rgb_sdram_wr_ctrl #(
    parameter int                H_DISP     = 480,
    parameter int                V_DISP     = 272,
    parameter int                BURST_LEN  = 64,
    parameter int                FIFO_DEPTH = 256,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] BANK_OFS   = 'h40000
) (
    input  logic              clk_24m,
    input  logic              rst_n,
    input  logic              RGB_vld,
    input  logic [15:0]       RGB_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              wr_ack,
    input  logic              wr_data_req,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              rd_bank,
    output logic              fifo_ovf
);

    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int FRAME_BURSTS = H_DISP * V_DISP / BURST_LEN;
    localparam int FB_W         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        DATA = 3'b100
    } state_t;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    state_t           state;
    logic [7:0]       beat_cnt;
    logic [FB_W-1:0]  burst_cnt;
    logic             wr_bank;

    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? BASE_ADDR + BANK_OFS : BASE_ADDR;
    endfunction

    assign full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (fifo_cnt == '0);
    assign push    = RGB_vld && !full;
    assign pop     = wr_data_req && !empty;
    // Show-ahead head; an empty FIFO presents zero so reset and flush look clean downstream.
    assign wr_data = empty ? 16'h0000 : mem[rd_ptr];
    assign wr_len  = 8'(BURST_LEN);

    always_ff @(posedge clk_24m) begin
        if (push)
            mem[wr_ptr] <= RGB_data;
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (RGB_vld && full)
                fifo_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_req     <= 1'b0;
            wr_addr    <= BASE_ADDR;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
                        wr_req <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (wr_ack) begin
                        wr_req   <= 1'b0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == 8'(BURST_LEN - 1)) begin
                            state <= IDLE;
                            if (burst_cnt == FB_W'(FRAME_BURSTS - 1)) begin
                                burst_cnt  <= '0;
                                frame_done <= 1'b1;
`ifdef PINGPONG_EN
                                // Publish the finished bank and move the writer to the other one.
                                wr_bank    <= ~wr_bank;
                                rd_bank    <= wr_bank;
                                wr_addr    <= bank_base(~wr_bank);
`else
                                wr_addr    <= bank_base(wr_bank);
`endif
                            end else begin
                                burst_cnt <= burst_cnt + FB_W'(1);
                                wr_addr   <= wr_addr + ADDR_W'(BURST_LEN);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_sdram_wr_ctrl.sv
// Directed bench for rgb_sdram_wr_ctrl: pixel scoreboard queue, burst addresses, frame wrap, overflow and reset abort.
module tb_rgb_sdram_wr_ctrl;

    localparam int          H     = 32;
    localparam int          V     = 8;
    localparam int          BL    = 64;
    localparam int          DEPTH = 256;
    localparam logic [23:0] BOFS  = 24'h040000;
`ifdef PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk_24m = 1'b0;
    logic        rst_n = 1'b0;
    logic        RGB_vld = 1'b0;
    logic [15:0] RGB_data = 16'h0;
    logic        wr_ack = 1'b0;
    logic        wr_data_req = 1'b0;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [7:0]  wr_len;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        rd_bank;
    logic        fifo_ovf;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    logic        exp_ovf = 1'b0;
    logic [15:0] pix = 16'h0;

    rgb_sdram_wr_ctrl #(
        .H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
        .ADDR_W(24), .BASE_ADDR(24'h0), .BANK_OFS(BOFS)
    ) dut (
        .clk_24m(clk_24m), .rst_n(rst_n), .RGB_vld(RGB_vld), .RGB_data(RGB_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_data_req(wr_data_req), .wr_data(wr_data), .frame_done(frame_done),
        .rd_bank(rd_bank), .fifo_ovf(fifo_ovf)
    );

    always #5 clk_24m = ~clk_24m;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the scoreboard, then check FIFO state after the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic rq, input logic ack);
        int n;
        logic [15:0] head;
        n = sb.size();
        RGB_vld = v;
        RGB_data = d;
        wr_data_req = rq;
        wr_ack = ack;
        if (rq && n > 0) begin
            head = sb.pop_front();
            chk("wr_data", 32'(wr_data), 32'(head));
        end
        if (v) begin
            if (n < DEPTH) sb.push_back(d);
            else exp_ovf = 1'b1;
        end
        @(posedge clk_24m);
        #1;
        RGB_vld = 1'b0;
        wr_data_req = 1'b0;
        wr_ack = 1'b0;
        chk("fifo_cnt", 32'(dut.fifo_cnt), 32'(sb.size()));
        chk("fifo_ovf", 32'(fifo_ovf), 32'(exp_ovf));
    endtask

    task automatic push_pix(input logic rq);
        step(1'b1, pix, rq, 1'b0);
        pix++;
    endtask

    task automatic burst(input logic [23:0] addr, input int ack_dly, input bit push_during,
                         input logic [23:0] next_addr, input logic fd);
        int t;
        t = 0;
        while (wr_req !== 1'b1 && t < 20) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            t++;
        end
        chk("wr_req_seen", 32'(wr_req), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'(addr));
        chk("wr_len", 32'(wr_len), 32'(BL));
        for (int i = 0; i < ack_dly; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            chk("wr_req_hold", 32'(wr_req), 32'd1);
            chk("wr_addr_hold", 32'(wr_addr), 32'(addr));
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("wr_req_drop", 32'(wr_req), 32'd0);
        for (int b = 0; b < BL; b++) begin
            if (push_during) push_pix(1'b1);
            else step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("next_addr", 32'(wr_addr), 32'(next_addr));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("no_back_to_back", 32'(wr_req), 32'd0);
    endtask

    task automatic run_frame(input logic [23:0] base, input logic [23:0] next_base,
                             input logic exp_rd);
        for (int i = 0; i < BL; i++) push_pix(1'b0);
        chk("req_latency_early", 32'(wr_req), 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("req_latency", 32'(wr_req), 32'd1);
        for (int k = 0; k < 4; k++)
            burst(base + 24'(BL * k), (k == 0) ? 2 : k % 2, k < 3,
                  (k == 3) ? next_base : base + 24'(BL * (k + 1)), k == 3);
        chk("rd_bank", 32'(rd_bank), 32'(exp_rd));
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("frame_done_clear", 32'(frame_done), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd0);
        chk("rst_fifo_ovf", 32'(fifo_ovf), 32'd0);
        chk("rst_fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
    endtask

    initial begin
        logic [23:0] bank1;
        int t;
        bank1 = PP ? BOFS : 24'h0;

        #12;
        chk_reset_outputs();
        chk("rst_wr_len", 32'(wr_len), 32'(BL));
        rst_n = 1'b1;
        @(posedge clk_24m);
        #1;

        // Two full frames; first burst carries pixels 0..63 with a 2-cycle ack delay.
        run_frame(24'h0, bank1, 1'b0);
        run_frame(bank1, 24'h0, PP);

        // Overflow: stream 300 pixels with no ack, then drain the first 256 in order.
        for (int i = 0; i < 300; i++) push_pix(1'b0);
        chk("ovf_cnt_sat", 32'(dut.fifo_cnt), 32'(DEPTH));
        chk("ovf_sticky", 32'(fifo_ovf), 32'd1);
        for (int k = 0; k < 4; k++)
            burst(24'(BL * k), 1, 1'b0, (k == 3) ? bank1 : 24'(BL * (k + 1)), k == 3);
        chk("ovf_rd_bank", 32'(rd_bank), 32'd0);
        chk("ovf_still_set", 32'(fifo_ovf), 32'd1);

        // Reset asserted during beat 30 of a burst.
        for (int i = 0; i < BL; i++) push_pix(1'b0);
        t = 0;
        while (wr_req !== 1'b1 && t < 20) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            t++;
        end
        chk("abort_req_seen", 32'(wr_req), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int b = 0; b < 30; b++) step(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        sb.delete();
        exp_ovf = 1'b0;
        @(posedge clk_24m);
        #1;
        chk("abort_req_low", 32'(wr_req), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_24m);
        #1;
        pix = 16'h5000;
        run_frame(24'h0, bank1, 1'b0);

        // Data request against an empty FIFO: no pop, head stays zero.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("empty_req_data", 32'(wr_data), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
